cp0_exc_ctrl: RTL and testbench

// - Coprocessor-0 exception/interrupt controller in M stage; source end of the PC-redirect path.
// - Decides whether an exception or interrupt is taken and produces Req plus the saved EPC.
// - Holds SR, Cause, EPC, PRId, Count and Compare; serves mfc0/mtc0/eret; timer feeds HWInt slot 5.

---
 rtl/cp0_exc_ctrl.sv | 151 +++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller for the M stage: decides whether to redirect
// the PC to the handler, saves EPC/Cause, and serves mfc0/mtc0/eret plus the Count/Compare timer.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID     = 32'h4255_4141,
  parameter bit          TIMER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] count_q;
  logic        timer_pend_q;

  logic        int_req, exc_req, req, wr;
  logic [31:0] epc_src, sr_val, cause_val;

  assign int_req = (|(ip_q & im_q)) & ie_q & ~exl_q;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl_q;
  assign req     = int_req | exc_req;
  // A synchronous exception code may be present while reset is held; never redirect then.
  assign Req     = req & ~reset;
  assign wr      = en & ~req;
  assign epc_src = BDIn ? (VPC - 32'd4) : VPC;

  always_comb begin
    ip_d      = HWInt | {timer_pend_q, 5'b0};
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    compare_d = compare_q;
    if (req) begin
      exl_d     = 1'b1;
      bd_d      = BDIn;
      exccode_d = int_req ? 5'd0 : ExcCodeIn;
      epc_d     = epc_src & 32'hFFFF_FFFC;
    end else begin
      if (wr) begin
        case (CP0Add)
          ADDR_SR: begin
            im_d  = CP0In[15:10];
            exl_d = CP0In[1];
            ie_d  = CP0In[0];
          end
          ADDR_EPC:     epc_d     = CP0In & 32'hFFFF_FFFC;
          ADDR_COMPARE: compare_d = CP0In;
          default: ;
        endcase
      end
      // eret overrides a simultaneous mtc0 to SR for the EXL bit only.
      if (EXLClr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
      compare_q <= '0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
      compare_q <= compare_d;
    end
  end

  generate
    if (TIMER_EN) begin : g_timer
      logic [31:0] count_d;
      logic        timer_pend_d;

      always_comb begin
        count_d      = (wr && CP0Add == ADDR_COUNT) ? CP0In : count_q + 32'd1;
        timer_pend_d = timer_pend_q;
        if (wr && CP0Add == ADDR_COMPARE)
          timer_pend_d = 1'b0;
        else if (count_q == compare_q && compare_q != 32'd0)
          timer_pend_d = 1'b1;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_q      <= '0;
          timer_pend_q <= 1'b0;
        end else begin
          count_q      <= count_d;
          timer_pend_q <= timer_pend_d;
        end
      end
    end else begin : g_no_timer
      assign count_q      = '0;
      assign timer_pend_q = 1'b0;
    end
  endgenerate

  assign sr_val    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};

  always_comb begin
    case (CP0Add)
      ADDR_SR:      CP0Out = sr_val;
      ADDR_CAUSE:   CP0Out = cause_val;
      ADDR_EPC:     CP0Out = epc_q;
      ADDR_PRID:    CP0Out = PRID;
      ADDR_COUNT:   CP0Out = count_q;
      ADDR_COMPARE: CP0Out = compare_q;
      default:      CP0Out = 32'd0;
    endcase
  end

  assign EPCOut = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scenario bench for cp0_exc_ctrl: expectations are queued when stimulus is driven and
// popped when the corresponding DUT response is sampled.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs, exp;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .CP0Out(CP0Out), .EPCOut(EPCOut), .Req(Req)
  );

  always #10 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    CP0Add = a;
    #1;
    d = CP0Out;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    en = 1'b1; CP0Add = a; CP0In = d;
    cyc();
    en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ExcCodeIn = 5'd4;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    cyc(); cyc();
    obs = {31'd0, Req}; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL rst_req: got %h want %h", obs, exp); end
    obs = EPCOut; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL rst_epcout: got %h want %h", obs, exp); end
    rd(5'd12, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL rst_sr: got %h want %h", obs, exp); end
    rd(5'd13, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL rst_cause: got %h want %h", obs, exp); end
    ExcCodeIn = 5'd0;
    cyc();
    reset = 1'b0;
    cyc();
    $display("[TB] reset checked");
  endtask

  task automatic test_exception();
    ExcCodeIn = 5'd4; VPC = 32'h3008; BDIn = 1'b0;
    exp_q.push_back(32'd1); exp_q.push_back(32'h2); exp_q.push_back(32'h10);
    exp_q.push_back(32'h3008); exp_q.push_back(32'h3008);
    #1;
    obs = {31'd0, Req}; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL exc_req: got %h want %h", obs, exp); end
    cyc();
    ExcCodeIn = 5'd0;
    rd(5'd12, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL exc_sr: got %h want %h", obs, exp); end
    rd(5'd13, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL exc_cause: got %h want %h", obs, exp); end
    rd(5'd14, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL exc_epc: got %h want %h", obs, exp); end
    obs = EPCOut; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL exc_epcout: got %h want %h", obs, exp); end
    $display("[TB] exception code 4 at 0x3008 checked");
  endtask

  task automatic test_delay_slot();
    EXLClr = 1'b1; cyc(); EXLClr = 1'b0;
    BDIn = 1'b1; VPC = 32'h3010; ExcCodeIn = 5'd10;
    exp_q.push_back(32'd1); exp_q.push_back(32'h300C); exp_q.push_back(32'h8000_0028);
    #1;
    obs = {31'd0, Req}; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL bd_req: got %h want %h", obs, exp); end
    cyc();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    rd(5'd14, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL bd_epc: got %h want %h", obs, exp); end
    rd(5'd13, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL bd_cause: got %h want %h", obs, exp); end
    ExcCodeIn = 5'd7; VPC = 32'h4000;
    exp_q.push_back(32'd0); exp_q.push_back(32'h300C);
    #1;
    obs = {31'd0, Req}; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL nested_req: got %h want %h", obs, exp); end
    cyc();
    ExcCodeIn = 5'd0;
    rd(5'd14, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL nested_epc: got %h want %h", obs, exp); end
    $display("[TB] delay-slot exception and nested exception checked");
  endtask

  task automatic test_interrupt();
    EXLClr = 1'b1; cyc(); EXLClr = 1'b0;
    wr(5'd12, 32'h0000_0401);
    HWInt = 6'b000001;
    exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    exp_q.push_back(32'h403); exp_q.push_back(32'h400); exp_q.push_back(32'h5000);
    #1;
    obs = {31'd0, Req}; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL int_latency: got %h want %h", obs, exp); end
    cyc();
    ExcCodeIn = 5'd4; VPC = 32'h5000;
    #1;
    obs = {31'd0, Req}; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL int_req: got %h want %h", obs, exp); end
    cyc();
    ExcCodeIn = 5'd0; HWInt = 6'b0;
    rd(5'd12, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL int_sr: got %h want %h", obs, exp); end
    rd(5'd13, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL int_cause: got %h want %h", obs, exp); end
    rd(5'd14, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL int_epc: got %h want %h", obs, exp); end
    EXLClr = 1'b1; cyc(); EXLClr = 1'b0;
    wr(5'd12, 32'h0000_0400);
    HWInt = 6'b000001;
    exp_q.push_back(32'd0);
    cyc(); cyc();
    obs = {31'd0, Req}; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL int_masked_ie: got %h want %h", obs, exp); end
    HWInt = 6'b0;
    cyc();
    $display("[TB] interrupt, priority and IE mask checked");
  endtask

  task automatic test_mtc0_conflict();
    ExcCodeIn = 5'd5; VPC = 32'h6000;
    en = 1'b1; CP0Add = 5'd14; CP0In = 32'h1234;
    exp_q.push_back(32'h6000); exp_q.push_back(32'h14);
    cyc();
    en = 1'b0; ExcCodeIn = 5'd0;
    rd(5'd14, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL conflict_epc: got %h want %h", obs, exp); end
    rd(5'd13, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL conflict_cause: got %h want %h", obs, exp); end
    EXLClr = 1'b1; en = 1'b1; CP0Add = 5'd12; CP0In = 32'h3;
    exp_q.push_back(32'h1);
    cyc();
    EXLClr = 1'b0; en = 1'b0;
    rd(5'd12, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL exlclr_wins: got %h want %h", obs, exp); end
    wr(5'd12, 32'h0);
    wr(5'd14, 32'hABCD_EF07);
    exp_q.push_back(32'hABCD_EF04);
    rd(5'd14, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL epc_align: got %h want %h", obs, exp); end
    ExcCodeIn = 5'd2; VPC = 32'h6100;
    exp_q.push_back(32'd1);
    #1;
    obs = {31'd0, Req}; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL refire_req: got %h want %h", obs, exp); end
    cyc();
    ExcCodeIn = 5'd0; EXLClr = 1'b1;
    cyc();
    EXLClr = 1'b0;
    $display("[TB] mtc0 conflict and eret checked");
  endtask

  task automatic test_timer();
    int k;
    wr(5'd12, 32'h0000_8001);
    wr(5'd11, 32'd5);
    wr(5'd9, 32'd0);
    exp_q.push_back(32'd7); exp_q.push_back(32'd1);
    k = 0;
    rd(5'd13, obs);
    while (obs[15] !== 1'b1 && k < 20) begin
      cyc();
      k++;
      rd(5'd13, obs);
    end
    obs = k; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL timer_latency: got %0d want %0d", obs, exp); end
    obs = {31'd0, Req}; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL timer_req: got %h want %h", obs, exp); end
    VPC = 32'h7000;
    exp_q.push_back(32'h8000); exp_q.push_back(32'd8); exp_q.push_back(32'h7000);
    cyc();
    rd(5'd13, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL timer_cause: got %h want %h", obs, exp); end
    rd(5'd9, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL timer_count: got %h want %h", obs, exp); end
    rd(5'd14, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL timer_epc: got %h want %h", obs, exp); end
    wr(5'd11, 32'd0);
    exp_q.push_back(32'h0);
    cyc();
    rd(5'd13, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL timer_clear: got %h want %h", obs, exp); end
    EXLClr = 1'b1; cyc(); EXLClr = 1'b0;
    $display("[TB] timer interrupt checked");
  endtask

  task automatic test_mfc0();
    exp_q.push_back(32'h4255_4141); exp_q.push_back(32'h0); exp_q.push_back(32'h0000_FC03);
    rd(5'd15, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL mfc0_prid: got %h want %h", obs, exp); end
    rd(5'd20, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL mfc0_unmapped: got %h want %h", obs, exp); end
    wr(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL sr_mask: got %h want %h", obs, exp); end
    $display("[TB] mfc0 reads checked");
  endtask

  task automatic test_reset_mid();
    #2;
    reset = 1'b1; ExcCodeIn = 5'd3;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    obs = {31'd0, Req}; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL midrst_req: got %h want %h", obs, exp); end
    rd(5'd12, obs); exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL midrst_sr: got %h want %h", obs, exp); end
    obs = EPCOut; exp = exp_q.pop_front(); tests_run++;
    if (obs !== exp) begin tests_failed++; $display("FAIL midrst_epcout: got %h want %h", obs, exp); end
    ExcCodeIn = 5'd0;
    cyc();
    reset = 1'b0;
    cyc();
    $display("[TB] reset during handler checked");
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; CP0Add = 5'd0; CP0In = 32'd0; VPC = 32'd0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    test_reset();
    test_exception();
    test_delay_slot();
    test_interrupt();
    test_mtc0_conflict();
    test_timer();
    test_mfc0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
